// File: rtl/diffeq_seq_host_if.sv
// Bundle of the command, solver-step and result-stream signals of diffeq_seq_host.
// master = the host itself, slave = the environment (command source, solver core, sample sink).
interface diffeq_seq_host_if #(
    parameter int W = 8
);
    // command channel
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_x0;
    logic [W-1:0] cmd_u0;
    logic [W-1:0] cmd_y0;
    logic [7:0]   cmd_niter;

    // solver step channel
    logic         sol_load;
    logic [W-1:0] sol_x0;
    logic [W-1:0] sol_u0;
    logic [W-1:0] sol_y0;
    logic         sol_req;
    logic         sol_ack;
    logic [W-1:0] sol_x;
    logic [W-1:0] sol_u;
    logic [W-1:0] sol_y;

    // result stream and status
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_x;
    logic [W-1:0] res_u;
    logic [W-1:0] res_y;
    logic         res_last;
    logic         busy;
    logic         err_timeout;

    modport master (
        input  cmd_valid, cmd_x0, cmd_u0, cmd_y0, cmd_niter,
        output cmd_ready,
        output sol_load, sol_x0, sol_u0, sol_y0, sol_req,
        input  sol_ack, sol_x, sol_u, sol_y,
        output res_valid, res_x, res_u, res_y, res_last,
        input  res_ready,
        output busy, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_x0, cmd_u0, cmd_y0, cmd_niter,
        input  cmd_ready,
        input  sol_load, sol_x0, sol_u0, sol_y0, sol_req,
        output sol_ack, sol_x, sol_u, sol_y,
        input  res_valid, res_x, res_u, res_y, res_last,
        output res_ready,
        input  busy, err_timeout
    );
endinterface

// File: rtl/diffeq_seq_host.sv
// Drives the x/u/y solver core step by step for one command and streams each step's
// result out of a show-ahead FIFO; a step is only requested when a FIFO slot is free.
module diffeq_seq_host #(
    parameter int W       = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    diffeq_seq_host_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 3 * W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAITSPC,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  x0_reg, u0_reg, y0_reg;
    logic [7:0]    niter_reg;
    logic [7:0]    step_reg;
    logic [TW-1:0] tmo_reg;
    logic          busy_reg;
    logic          err_reg;

    // result FIFO: {x, u, y, last} per entry
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [EW-1:0] head;

    logic fifo_full, fifo_empty;
    logic push, pop;
    logic cmd_accept;
    logic step_last;
    logic tmo_clr, tmo_inc, tmo_hit;

    assign fifo_full  = (count_reg == (AW + 1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && bus.res_ready;
    assign step_last  = (step_reg == niter_reg - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_accept = 1'b0;
        push       = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        tmo_hit    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_next = (bus.cmd_niter == 8'd0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: state_next = S_WAITSPC;
            S_WAITSPC: begin
                // never ask for a step unless its result already has a home
                if (!fifo_full) begin
                    tmo_clr    = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sol_ack) begin
                    push       = 1'b1;
                    state_next = step_last ? S_DRAIN : S_WAITSPC;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    state_next = S_DRAIN;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_DRAIN: if (fifo_empty) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_reg    <= '0;
            u0_reg    <= '0;
            y0_reg    <= '0;
            niter_reg <= '0;
        end else if (cmd_accept) begin
            x0_reg    <= bus.cmd_x0;
            u0_reg    <= bus.cmd_u0;
            y0_reg    <= bus.cmd_y0;
            niter_reg <= bus.cmd_niter;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             step_reg <= '0;
        else if (cmd_accept) step_reg <= '0;
        else if (push)       step_reg <= step_reg + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tmo_reg <= '0;
        else if (tmo_clr) tmo_reg <= '0;
        else if (tmo_inc) tmo_reg <= tmo_reg + TW'(1);
    end

    // busy is registered so a zero-step command still shows one busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        busy_reg <= 1'b0;
        else if (cmd_accept)                            busy_reg <= 1'b1;
        else if (state_reg == S_DRAIN && fifo_empty)    busy_reg <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_reg <= 1'b0;
        else if (cmd_accept) err_reg <= 1'b0;
        else if (tmo_hit)    err_reg <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {bus.sol_x, bus.sol_u, bus.sol_y, step_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // head is masked so stale storage never shows while the FIFO is empty
    assign head = fifo_empty ? '0 : mem[rd_ptr_reg];

    assign bus.cmd_ready   = (state_reg == S_IDLE);
    assign bus.sol_load    = (state_reg == S_LOAD);
    assign bus.sol_req     = (state_reg == S_REQ);
    assign bus.sol_x0      = x0_reg;
    assign bus.sol_u0      = u0_reg;
    assign bus.sol_y0      = y0_reg;
    assign bus.res_valid   = !fifo_empty;
    assign bus.res_x       = head[EW-1 -: W];
    assign bus.res_u       = head[2*W -: W];
    assign bus.res_y       = head[W -: W];
    assign bus.res_last    = head[0];
    assign bus.busy        = busy_reg;
    assign bus.err_timeout = err_reg;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);
endmodule

// File: tb/tb_diffeq_seq_host.sv
// Randomized bench for diffeq_seq_host: a cycle-stepped solver/sink model feeds the DUT and
// the collected samples are compared against the per-command sequence the solver was told to return.
module tb_diffeq_seq_host;
    localparam int W       = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    diffeq_seq_host_if #(.W(W)) bus ();
    diffeq_seq_host #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] u;
        logic [W-1:0] y;
        logic         last;
    } sample_t;

    sample_t      rx_q[$];
    sample_t      exp_q[$];
    logic [W-1:0] sd_x[256];
    logic [W-1:0] sd_u[256];
    logic [W-1:0] sd_y[256];
    logic [W-1:0] ld_x, ld_u, ld_y;

    int vectors = 0, miscompares = 0;
    int cyc = 0, load_cnt = 0, ack_cnt = 0, req_cycles = 0;
    int first_req_cyc = -1, acc_cyc = 0, idle_cyc = 0, last_pop_cyc = 0;
    int sk = 0, wait_cnt = 0, ack_delay = 0;
    bit ack_en = 1'b1, spurious = 1'b0, rand_ready = 1'b0, ready_hold = 1'b1;
    logic last_pop_busy = 1'b0;

    // One clock of the environment: observe outputs, choose next inputs, log handshakes
    // that the coming rising edge will complete.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.sol_load) begin
            load_cnt++;
            ld_x = bus.sol_x0; ld_u = bus.sol_u0; ld_y = bus.sol_y0;
            sk = 0; wait_cnt = 0; first_req_cyc = -1;
        end
        if (bus.sol_req) begin
            req_cycles++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        bus.sol_ack = 1'b0;
        if (rst) begin
            sk = 0; wait_cnt = 0;
        end else if (bus.sol_req && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                bus.sol_ack = 1'b1;
                bus.sol_x = sd_x[sk & 255]; bus.sol_u = sd_u[sk & 255]; bus.sol_y = sd_y[sk & 255];
            end else begin
                wait_cnt++;
            end
        end else if (spurious) begin
            bus.sol_ack = 1'b1;
            bus.sol_x = W'($urandom); bus.sol_u = W'($urandom); bus.sol_y = W'($urandom);
        end
        bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
        if (!rst && bus.sol_ack && bus.sol_req) begin
            sk++; ack_cnt++; wait_cnt = 0;
        end
        if (!rst && bus.res_valid && bus.res_ready) begin
            rx_q.push_back({bus.res_x, bus.res_u, bus.res_y, bus.res_last});
            if (bus.res_last) begin
                last_pop_busy = bus.busy;
                last_pop_cyc  = cyc;
            end
        end
    endtask

    task automatic issue_cmd(input logic [W-1:0] x, input logic [W-1:0] u, input logic [W-1:0] y,
                             input int n, output bit ok);
        int guard = 0;
        bus.cmd_x0 = x; bus.cmd_u0 = u; bus.cmd_y0 = y; bus.cmd_niter = 8'(n);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && guard < 1000) begin
            tick();
            guard++;
        end
        ok = bus.cmd_ready;
        tick();
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        $display("cmd x0=%0d u0=%0d y0=%0d niter=%0d accepted_at=%0d", x, u, y, n, acc_cyc);
    endtask

    task automatic run_idle(input int budget, output bit ok);
        int guard = 0;
        while (!(bus.cmd_ready && !bus.busy) && guard < budget) begin
            tick();
            guard++;
        end
        ok = bus.cmd_ready && !bus.busy;
        idle_cyc = cyc;
    endtask

    // Reference: step k of a command yields exactly the k-th triple handed to the solver,
    // and only the final step of the command carries last.
    function automatic void build_expected(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back({sd_x[k], sd_u[k], sd_y[k], 1'(k == n - 1)});
    endfunction

    function automatic void fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            sd_x[k] = W'($urandom); sd_u[k] = W'($urandom); sd_y[k] = W'($urandom);
        end
    endfunction

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_u0 = '0; bus.cmd_y0 = '0; bus.cmd_niter = '0;
        bus.sol_ack = 1'b0; bus.sol_x = '0; bus.sol_u = '0; bus.sol_y = '0; bus.res_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.sol_load, bus.sol_req, bus.res_valid, bus.busy, bus.err_timeout} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 100000", {bus.cmd_ready, bus.sol_load, bus.sol_req, bus.res_valid, bus.busy, bus.err_timeout});
        end
        vectors++;
        if ({bus.sol_x0, bus.sol_u0, bus.sol_y0, bus.res_x, bus.res_u, bus.res_y, bus.res_last} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {bus.sol_x0, bus.sol_u0, bus.sol_y0, bus.res_x, bus.res_u, bus.res_y, bus.res_last});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok_c, ok_i;
        int l0 = load_cnt;
        rx_q.delete();
        for (int k = 0; k < 256; k++) begin
            sd_x[k] = W'(k); sd_u[k] = W'(k + 10); sd_y[k] = W'(k + 20);
        end
        ack_en = 1'b1; ack_delay = 1; rand_ready = 1'b0; ready_hold = 1'b1;
        issue_cmd(8'd1, 8'd2, 8'd3, 3, ok_c);
        run_idle(200, ok_i);
        build_expected(3);
        vectors++;
        if (!(ok_c && ok_i)) begin miscompares++; $display("FAIL basic_handshake: got accept=%0b idle=%0b expected 1 1", ok_c, ok_i); end
        vectors++;
        if (load_cnt - l0 != 1) begin miscompares++; $display("FAIL basic_load_pulses: got %0d expected 1", load_cnt - l0); end
        vectors++;
        if ({ld_x, ld_u, ld_y} !== {8'd1, 8'd2, 8'd3}) begin miscompares++; $display("FAIL basic_load_vals: got %0d/%0d/%0d expected 1/2/3", ld_x, ld_u, ld_y); end
        vectors++;
        if (first_req_cyc - acc_cyc != 2) begin miscompares++; $display("FAIL basic_req_spacing: got %0d expected 2", first_req_cyc - acc_cyc); end
        vectors++;
        if (rx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_sample[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        vectors++;
        if (last_pop_busy !== 1'b1 || idle_cyc - last_pop_cyc != 2) begin
            miscompares++;
            $display("FAIL basic_busy_fall: got busy_at_pop=%0b fall_after=%0d expected 1 and 2", last_pop_busy, idle_cyc - last_pop_cyc);
        end
    endtask

    task automatic test_zero_iter();
        bit ok_c, ok_i;
        int l0 = load_cnt, r0 = req_cycles;
        logic busy_after;
        rx_q.delete();
        issue_cmd(8'd9, 8'd9, 8'd9, 0, ok_c);
        busy_after = bus.busy;
        run_idle(10, ok_i);
        vectors++;
        if (!(ok_c && ok_i) || busy_after !== 1'b1) begin miscompares++; $display("FAIL zero_busy: got accept=%0b busy=%0b idle=%0b expected 1 1 1", ok_c, busy_after, ok_i); end
        vectors++;
        if (idle_cyc - acc_cyc != 1) begin miscompares++; $display("FAIL zero_busy_len: got %0d expected 1", idle_cyc - acc_cyc); end
        vectors++;
        if (load_cnt != l0 || req_cycles != r0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_activity: got loads=%0d reqs=%0d samples=%0d expected 0 0 0", load_cnt - l0, req_cycles - r0, rx_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok_c, ok_i;
        int a0 = ack_cnt;
        rx_q.delete();
        fill_random(12);
        ack_delay = 0; ready_hold = 1'b0;
        issue_cmd(W'($urandom), W'($urandom), W'($urandom), 12, ok_c);
        repeat (40) tick();
        vectors++;
        if (ack_cnt - a0 != DEPTH || bus.sol_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: got acks=%0d sol_req=%0b expected %0d 0", ack_cnt - a0, bus.sol_req, DEPTH);
        end
        ready_hold = 1'b1;
        run_idle(300, ok_i);
        build_expected(12);
        vectors++;
        if (!(ok_c && ok_i) || ack_cnt - a0 != 12 || rx_q.size() != 12) begin
            miscompares++;
            $display("FAIL bp_count: got acks=%0d samples=%0d idle=%0b expected 12 12 1", ack_cnt - a0, rx_q.size(), ok_i);
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_sample[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        bit ok_c, ok_i;
        int r0 = req_cycles;
        rx_q.delete();
        ack_en = 1'b0;
        issue_cmd(8'd4, 8'd5, 8'd6, 5, ok_c);
        run_idle(400, ok_i);
        vectors++;
        if (req_cycles - r0 != TIMEOUT) begin miscompares++; $display("FAIL tmo_req_len: got %0d expected %0d", req_cycles - r0, TIMEOUT); end
        vectors++;
        if (!(ok_c && ok_i) || bus.err_timeout !== 1'b1 || bus.sol_req !== 1'b0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL tmo_state: got idle=%0b err=%0b req=%0b samples=%0d expected 1 1 0 0", ok_i, bus.err_timeout, bus.sol_req, rx_q.size());
        end
        ack_en = 1'b1;
        fill_random(1);
        issue_cmd(8'd7, 8'd8, 8'd9, 1, ok_c);
        vectors++;
        if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %0b expected 0", bus.err_timeout); end
        run_idle(100, ok_i);
        build_expected(1);
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL tmo_next_cmd: got n=%0d head=%h expected 1 %h", rx_q.size(), rx_q.size() ? rx_q[0] : '0, exp_q[0]); end
    endtask

    task automatic test_async_reset();
        bit ok_c;
        int a0 = ack_cnt, guard = 0;
        rx_q.delete();
        fill_random(10);
        ack_delay = 2; ready_hold = 1'b0;
        issue_cmd(8'd1, 8'd1, 8'd1, 10, ok_c);
        while (!(ack_cnt - a0 == 3 && bus.sol_req && !bus.sol_ack) && guard < 100) begin
            tick();
            guard++;
        end
        vectors++;
        if (ack_cnt - a0 != 3 || bus.sol_req !== 1'b1 || bus.res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup: got acks=%0d req=%0b valid=%0b expected 3 1 1", ack_cnt - a0, bus.sol_req, bus.res_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.sol_req, bus.res_valid, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL arst_immediate: got req/valid/busy=%b expected 000", {bus.sol_req, bus.res_valid, bus.busy});
        end
        bus.sol_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        ready_hold = 1'b1;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_release: got ready=%0b valid=%0b busy=%0b expected 1 0 0", bus.cmd_ready, bus.res_valid, bus.busy);
        end
        ack_delay = 0;
    endtask

    task automatic test_spurious();
        bit ok_c, ok_i;
        int a0;
        rx_q.delete();
        spurious = 1'b1;
        repeat (5) tick();
        spurious = 1'b0;
        tick();
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL spur_idle: got valid=%0b busy=%0b expected 0 0", bus.res_valid, bus.busy); end
        fill_random(10);
        a0 = ack_cnt;
        ready_hold = 1'b0;
        issue_cmd(8'd2, 8'd3, 8'd4, 10, ok_c);
        repeat (30) tick();
        spurious = 1'b1;
        repeat (6) tick();
        spurious = 1'b0;
        vectors++;
        if (ack_cnt - a0 != DEPTH || bus.sol_req !== 1'b0) begin miscompares++; $display("FAIL spur_wait: got acks=%0d req=%0b expected %0d 0", ack_cnt - a0, bus.sol_req, DEPTH); end
        ready_hold = 1'b1;
        run_idle(300, ok_i);
        build_expected(10);
        vectors++;
        if (!(ok_c && ok_i) || rx_q.size() != 10) begin miscompares++; $display("FAIL spur_count: got %0d idle=%0b expected 10 1", rx_q.size(), ok_i); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL spur_sample[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok_c, ok_i;
        int n;
        rand_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rx_q.delete();
            n = $urandom_range(1, 20);
            fill_random(n);
            ack_delay = $urandom_range(0, 3);
            issue_cmd(W'($urandom), W'($urandom), W'($urandom), n, ok_c);
            run_idle(2000, ok_i);
            build_expected(n);
            vectors++;
            if (!(ok_c && ok_i) || rx_q.size() != n) begin miscompares++; $display("FAIL rand%0d_count: got %0d idle=%0b expected %0d 1", c, rx_q.size(), ok_i, n); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                vectors++;
                if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_sample[%0d]: got %h expected %h", c, i, rx_q[i], exp_q[i]); end
            end
        end
        rand_ready = 1'b0;
        ready_hold = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_iter();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
